// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// Optional build macro used by this slice: PC_GEN_ALIGN_CHECK_EN.
package pc_gen_pkg;

    // Reset sequencing: held in reset, one idle wake cycle, then fetching.
    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2
    } pc_state_e;

    // What kind of redirect is sitting in the pending buffer.
    typedef enum logic [1:0] {
        PEND_NONE   = 2'd0,
        PEND_BRANCH = 2'd1,
        PEND_FLUSH  = 2'd2
    } pend_kind_e;

    // Values matching the legacy defines.v encoding.
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic NoStop      = 1'b0;
    localparam logic Stop        = 1'b1;

    // True when a stall bit requests the stage to hold.
    function automatic logic is_stop(input logic stall_bit);
        return (stall_bit == Stop);
    endfunction

endpackage

// File: rtl/pc_redir_buf.sv
// One-entry pending-redirect buffer. Captures a flush or branch target
// while the fetch stage is held, so the redirect is applied on the first
// advancing edge. A buffered flush is never displaced by a later branch.
module pc_redir_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_en,
    input  logic              clear_en,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_target_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              pend_valid_o,
    output logic [ADDR_W-1:0] pend_target_o
);

    pend_kind_e        kind_r;
    pend_kind_e        kind_next_s;
    logic [ADDR_W-1:0] target_r;
    logic [ADDR_W-1:0] target_next_s;

    // Capture priority: flush always wins, a branch only lands if no flush is buffered.
    always_comb begin
        kind_next_s   = kind_r;
        target_next_s = target_r;
        if (clear_en) begin
            kind_next_s   = PEND_NONE;
            target_next_s = {ADDR_W{1'b0}};
        end else if (hold_en) begin
            if (flush_i) begin
                kind_next_s   = PEND_FLUSH;
                target_next_s = flush_target_i;
            end else if (branch_flag_i && (kind_r != PEND_FLUSH)) begin
                kind_next_s   = PEND_BRANCH;
                target_next_s = branch_target_i;
            end else begin
                kind_next_s   = kind_r;
                target_next_s = target_r;
            end
        end else begin
            kind_next_s   = kind_r;
            target_next_s = target_r;
        end
    end

    // Pending kind and target registers; reset discards any buffered redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_r   <= PEND_NONE;
            target_r <= {ADDR_W{1'b0}};
        end else begin
            kind_r   <= kind_next_s;
            target_r <= target_next_s;
        end
    end

    assign pend_valid_o  = (kind_r != PEND_NONE);
    assign pend_target_o = target_r;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: reset sequencing FSM, PC register and ROM ce.
// Redirect priority is flush, then buffered redirect, then branch, then
// sequential. Define PC_GEN_ALIGN_CHECK_EN to force redirect targets onto
// instruction boundaries and flag misaligned ones on misalign_o.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h00000000,
    parameter int                STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  flush_target_i,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               if_ready_i,
`ifdef PC_GEN_ALIGN_CHECK_EN
    output logic               misalign_o,
`endif
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redir_pending_o
);

    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

    pc_state_e         state_r;
    pc_state_e         state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic              ce_r;
    logic              run_s;
    logic              advance_s;
    logic              pend_valid_s;
    logic [ADDR_W-1:0] pend_target_s;
    logic              redir_s;
    logic [ADDR_W-1:0] redir_target_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic              stall_unused_s;

    // Only stall[0] steers this stage; the rest of the vector is for later stages.
    assign stall_unused_s = ^stall;

    assign run_s     = (state_r == ST_RUN);
    assign advance_s = run_s && !is_stop(stall[0]) && if_ready_i;

    pc_redir_buf #(
        .ADDR_W(ADDR_W)
    ) u_redir_buf (
        .clk             (clk),
        .rst             (rst),
        .hold_en         (run_s && !advance_s),
        .clear_en        (advance_s),
        .flush_i         (flush_i),
        .flush_target_i  (flush_target_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_address_i),
        .pend_valid_o    (pend_valid_s),
        .pend_target_o   (pend_target_s)
    );

    // Reset sequencing state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RST;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Reset sequencing next state: one wake cycle before fetching starts.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RST:  state_next_s = ST_WAKE;
            ST_WAKE: state_next_s = ST_RUN;
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_RST;
        endcase
    end

    // Next-PC selection by redirect priority; sequential fetch wraps silently.
    always_comb begin
        redir_s        = 1'b1;
        redir_target_s = flush_target_i;
        if (flush_i) begin
            redir_target_s = flush_target_i;
        end else if (pend_valid_s) begin
            redir_target_s = pend_target_s;
        end else if (branch_flag_i) begin
            redir_target_s = branch_target_address_i;
        end else begin
            redir_s        = 1'b0;
            redir_target_s = {ADDR_W{1'b0}};
        end
        if (redir_s) begin
`ifdef PC_GEN_ALIGN_CHECK_EN
            next_pc_s = redir_target_s & ~LOW_MASK;
`else
            next_pc_s = redir_target_s;
`endif
        end else begin
            next_pc_s = pc_r + PC_INC;
        end
    end

    // PC and chip-enable registers; pc only moves on an advancing RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r <= RESET_VECTOR;
            ce_r <= ChipDisable;
        end else begin
            ce_r <= (state_next_s == ST_RUN) ? ChipEnable : ChipDisable;
            if (advance_s) begin
                pc_r <= next_pc_s;
            end else begin
                pc_r <= pc_r;
            end
        end
    end

`ifdef PC_GEN_ALIGN_CHECK_EN
    logic misalign_r;

    // One-cycle flag when an applied redirect target had low address bits set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= advance_s && redir_s && ((redir_target_s & LOW_MASK) != {ADDR_W{1'b0}});
        end
    end

    assign misalign_o = misalign_r;
`endif

    assign pc              = pc_r;
    assign ce              = ce_r;
    assign redir_pending_o = pend_valid_s;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
// Honours PC_GEN_ALIGN_CHECK_EN for the misalign_o output.
module tb_pc_gen;

    localparam int          AW = 32;
    localparam int          IB = 4;
    localparam logic [31:0] RV = 32'h00000000;
    localparam int          SW = 6;

    logic          clk;
    logic          rst;
    logic [SW-1:0] stall;
    logic          flush_i;
    logic [AW-1:0] flush_target_i;
    logic          branch_flag_i;
    logic [AW-1:0] branch_target_address_i;
    logic          if_ready_i;
    logic [AW-1:0] pc;
    logic          ce;
    logic          redir_pending_o;
`ifdef PC_GEN_ALIGN_CHECK_EN
    logic          misalign_o;
`endif

    pc_gen #(
        .ADDR_W      (AW),
        .INST_BYTES  (IB),
        .RESET_VECTOR(RV),
        .STALL_W     (SW)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush_i                 (flush_i),
        .flush_target_i          (flush_target_i),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .if_ready_i              (if_ready_i),
`ifdef PC_GEN_ALIGN_CHECK_EN
        .misalign_o              (misalign_o),
`endif
        .pc                      (pc),
        .ce                      (ce),
        .redir_pending_o         (redir_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cycles since reset release, pc, ce, pending redirect.
    int          m_phase;
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_pv;
    logic        m_pf;
    logic [31:0] m_pt;
    logic        m_mis;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = RV;
        m_ce    = 1'b0;
        m_pv    = 1'b0;
        m_pf    = 1'b0;
        m_pt    = 32'h0;
        m_mis   = 1'b0;
    endtask

    // Applies the behavioural rules for one rising edge using the driven inputs.
    task automatic model_edge();
        logic        adv;
        logic        have;
        logic [31:0] t;
        if (!rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_ce    = 1'b1;
        end else begin
            adv   = !stall[0] && if_ready_i;
            m_mis = 1'b0;
            if (adv) begin
                have = 1'b1;
                t    = 32'h0;
                if (flush_i)            t = flush_target_i;
                else if (m_pv)          t = m_pt;
                else if (branch_flag_i) t = branch_target_address_i;
                else                    have = 1'b0;
                if (have) begin
`ifdef PC_GEN_ALIGN_CHECK_EN
                    m_mis = ((t % IB) != 0);
                    m_pc  = t - (t % IB);
`else
                    m_pc  = t;
`endif
                end else begin
                    m_pc = m_pc + 32'(IB);
                end
                m_pv = 1'b0;
                m_pf = 1'b0;
            end else if (flush_i) begin
                m_pv = 1'b1;
                m_pf = 1'b1;
                m_pt = flush_target_i;
            end else if (branch_flag_i && !(m_pv && m_pf)) begin
                m_pv = 1'b1;
                m_pf = 1'b0;
                m_pt = branch_target_address_i;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"}, 64'(pc), 64'(m_pc));
        check({tag, ".ce"}, 64'(ce), 64'(m_ce));
        check({tag, ".pend"}, 64'(redir_pending_o), 64'(m_pv));
`ifdef PC_GEN_ALIGN_CHECK_EN
        check({tag, ".mis"}, 64'(misalign_o), 64'(m_mis));
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, model the rising edge, check after.
    task automatic step(input string tag, input logic st, input logic rdy,
                        input logic fl, input logic [31:0] ft,
                        input logic br, input logic [31:0] bt);
        stall                   = {5'($urandom), st};
        if_ready_i              = rdy;
        flush_i                 = fl;
        flush_target_i          = ft;
        branch_flag_i           = br;
        branch_target_address_i = bt;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Asserts reset between edges and checks the outputs respond without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check({tag, ".pc"}, 64'(pc), 64'(RV));
        check({tag, ".ce"}, 64'(ce), 64'h0);
        check({tag, ".pend"}, 64'(redir_pending_o), 64'h0);
        @(negedge clk);
        idle({tag, ".held"});
        rst = 1'b1;
    endtask

    initial begin
        logic        st;
        logic        rdy;
        logic        fl;
        logic        br;
        logic [31:0] ft;
        logic [31:0] bt;

        rst                     = 1'b0;
        stall                   = '0;
        flush_i                 = 1'b0;
        flush_target_i          = 32'h0;
        branch_flag_i           = 1'b0;
        branch_target_address_i = 32'h0;
        if_ready_i              = 1'b1;
        model_reset();

        @(negedge clk);
        compare_all("reset");
        idle("reset_hold");
        rst = 1'b1;

        // Release: one idle edge, then fetch from the reset vector.
        idle("wake");
        check("wake_ce_low", 64'(ce), 64'h0);
        idle("run0");
        idle("run1");
        idle("run2");
        idle("run3");
        check("seq_pc_c", 64'(pc), 64'h0000000C);

        // Unstalled branch.
        step("br100", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000100);
        check("br100_pc", 64'(pc), 64'h00000100);
        idle("br100_seq");
        check("br100_next", 64'(pc), 64'h00000104);

        // Branch captured during a three-cycle stall.
        step("st_br200", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000200);
        check("st_br200_pend", 64'(redir_pending_o), 64'h1);
        step("st_hold1", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step("st_hold2", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("st_hold_pc", 64'(pc), 64'h00000104);
        idle("st_release");
        check("st_release_pc", 64'(pc), 64'h00000200);
        check("st_release_pend", 64'(redir_pending_o), 64'h0);

        // Buffered branch overwritten by a later flush.
        step("bf_br", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000300);
        step("bf_fl", 1'b1, 1'b1, 1'b1, 32'h00000080, 1'b0, 32'h0);
        idle("bf_release");
        check("bf_pc", 64'(pc), 64'h00000080);

        // Buffered flush survives a later branch.
        step("fb_fl", 1'b1, 1'b1, 1'b1, 32'h00000080, 1'b0, 32'h0);
        step("fb_br", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000300);
        idle("fb_release");
        check("fb_pc", 64'(pc), 64'h00000080);

        // Flush and branch in one held cycle, released by if_ready rather than stall.
        step("both", 1'b0, 1'b0, 1'b1, 32'h00000500, 1'b1, 32'h00000600);
        idle("both_release");
        check("both_pc", 64'(pc), 64'h00000500);

        // Live flush overrides a buffered branch on the advancing edge.
        step("ov_br", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000700);
        step("ov_fl", 1'b0, 1'b1, 1'b1, 32'h00000040, 1'b0, 32'h0);
        check("ov_pc", 64'(pc), 64'h00000040);

        // Sequential wrap at the top of the address space.
        step("wrap_br", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFC);
        idle("wrap");
        check("wrap_pc", 64'(pc), 64'h00000000);

        // Reset mid-run with a redirect buffered.
        step("rst_pend", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000400);
        check("rst_pend_set", 64'(redir_pending_o), 64'h1);
        async_reset("midrst");
        idle("midrst_wake");
        idle("midrst_run");
        idle("midrst_seq");
        check("midrst_pc", 64'(pc), 64'(RV + 32'(IB)));

`ifdef PC_GEN_ALIGN_CHECK_EN
        step("mis_br", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000102);
        check("mis_pc", 64'(pc), 64'h00000100);
        check("mis_flag", 64'(misalign_o), 64'h1);
        idle("mis_after");
        check("mis_drop", 64'(misalign_o), 64'h0);
`endif

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 5) != 0);
            fl  = ($urandom_range(0, 9) == 0);
            br  = ($urandom_range(0, 4) == 0);
            ft  = $urandom;
            bt  = $urandom;
`ifndef PC_GEN_ALIGN_CHECK_EN
            ft  = ft & ~32'(IB - 1);
            bt  = bt & ~32'(IB - 1);
`endif
            step("rand", st, rdy, fl, ft, br, bt);
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
